user_stream_fifo: RTL and testbench
===================================

Name: user_stream_fifo

Overview:
- Elastic buffer on one 32-bit vld/ack stream channel between a user kernel output port and the leaf interface input port in a leaf shell.
- One instance per output port, so a kernel can keep producing while the leaf interface is back-pressured by BFT freespace.
- Runs entirely in the user clock domain and is first-word-fall-through.
- Exposes occupancy and a transfer counter for debug readback.

Parameters:
- PAYLOAD_BITS, 32, data width of the stream.
- DEPTH_BITS, 4, log2 of storage depth; DEPTH = 2**DEPTH_BITS entries (default 16).
- ALMOST_FULL_LEVEL, 12, occupancy at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  user clock; connected to clk_user in the leaf shell.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties the buffer in one cycle.
- din_user2fifo  in  PAYLOAD_BITS  write data from the user kernel.
- vld_user2fifo  in  1  write valid from the user kernel.
- ack_fifo2user  out  1  write ready to the user kernel.
- dout_fifo2interface  out  PAYLOAD_BITS  head-of-queue data, i.e. din_leaf_user2interface_N.
- vld_fifo2interface  out  1  head valid, i.e. vld_user2interface_N.
- ack_interface2fifo  in  1  read ready, i.e. ack_interface2user_N.
- occupancy  out  DEPTH_BITS+1  number of stored words.
- almost_full  out  1  asserted when occupancy >= ALMOST_FULL_LEVEL.
- xfer_cnt  out  32  words accepted by the interface since reset or clear; wraps modulo 2**32.

Behaviour:
- Handshake: a transfer on either side occurs in a cycle where vld and ack are both high at the rising edge of clk.
  - Producers must hold data stable while vld is high and ack is low.
  - This block holds dout stable while vld_fifo2interface=1 and ack_interface2fifo=0.
- Storage: DEPTH-entry register array or LUTRAM with a write pointer, a read pointer (DEPTH_BITS each, natural wrap) and a registered occupancy counter.
- Push = vld_user2fifo & ack_fifo2user. Pop = vld_fifo2interface & ack_interface2fifo.
- ack_fifo2user is a registered output:
  - high iff next-cycle occupancy < DEPTH;
  - is never combinationally dependent on ack_interface2fifo;
  - when full, a same-cycle pop does not open the write port until the following cycle.
- vld_fifo2interface is registered and equals (occupancy != 0).
- dout_fifo2interface is the entry at the read pointer.
- Latency:
  - a word pushed at edge N is presented with vld high after edge N;
  - it can be popped at edge N+1 at the earliest.
  - There is no combinational bypass from din to dout.
- Occupancy update per edge: +1 on push only, -1 on pop only, unchanged on push & pop or on neither.
- Full boundary:
  - occupancy = DEPTH means ack_fifo2user = 0;
  - a vld_user2fifo held high is ignored (no overwrite).
- Empty boundary:
  - occupancy = 0 means vld_fifo2interface = 0;
  - the ack_interface2fifo value is ignored and no underflow occurs.
- Simultaneous push and pop at occupancy 1 through DEPTH-1: both pointers advance, occupancy unchanged, and order is preserved.
- xfer_cnt increments by 1 on every pop and wraps from 0xFFFFFFFF to 0.
- almost_full is registered and derived from next-cycle occupancy.
- clear (synchronous, takes priority over push and pop in the same cycle):
  - pointers, occupancy and xfer_cnt go to 0;
  - vld_fifo2interface = 0 and ack_fifo2user = 1 after the edge;
  - any word offered in the clear cycle is dropped.
- Reset (asynchronous assert; mid-operation reset discards contents immediately). Reset values:
  - ack_fifo2user = 0, vld_fifo2interface = 0, occupancy = 0, almost_full = 0, xfer_cnt = 0, pointers = 0;
  - dout_fifo2interface = 0 (storage array need not be reset).
  - ack_fifo2user rises on the first clk edge after reset deasserts.
- No state machine beyond the pointer and occupancy state. Output data order is strictly FIFO.

Test Plan:
- Reset release with vld_user2fifo=1 and din=0xA5A5_0001 held → ack_fifo2user is 0 during reset and 1 one edge after deassertion. The word is accepted on the next edge, and vld_fifo2interface rises one edge later with dout=0xA5A5_0001.
- Fill with ack_interface2fifo=0, pushing 0x0..0xF then offering 0x10 → occupancy=16, ack_fifo2user=0, almost_full=1 from occupancy 12. Word 0x10 is not stored. Draining yields 0x0..0xF in order with xfer_cnt=16.
- Continuous streaming with both sides always valid/ready for 100 words 0..99 → all words appear in order, occupancy stays at 1 after the first word, xfer_cnt=100.
- Random vld and ack at 50% each for 10,000 words → scoreboard matches exactly, occupancy never exceeds 16, and there are no pops while vld_fifo2interface=0.
- clear asserted at occupancy 7 together with a push of 0xDEAD_BEEF → next cycle occupancy=0, vld_fifo2interface=0, xfer_cnt=0, ack_fifo2user=1, and 0xDEAD_BEEF never appears on the output.
- Asynchronous reset pulsed mid-stream at occupancy 5 between clock edges → outputs go to their reset values immediately, and the stream restarts cleanly from the next pushed word.

Source files
------------

// File: rtl/user_stream_fifo.sv
// First-word-fall-through elastic buffer for one vld/ack stream channel
// between a user kernel output port and the leaf interface input port.
module user_stream_fifo #(
  parameter int PAYLOAD_BITS      = 32,
  parameter int DEPTH_BITS        = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [PAYLOAD_BITS-1:0] din_user2fifo,
  input  logic                    vld_user2fifo,
  output logic                    ack_fifo2user,
  output logic [PAYLOAD_BITS-1:0] dout_fifo2interface,
  output logic                    vld_fifo2interface,
  input  logic                    ack_interface2fifo,
  output logic [DEPTH_BITS:0]     occupancy,
  output logic                    almost_full,
  output logic [31:0]             xfer_cnt
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_LVL = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] AF_LVL    = (DEPTH_BITS + 1)'(ALMOST_FULL_LEVEL);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   rd_ptr;
  logic [DEPTH_BITS:0]     occ_next;
  logic                    push;
  logic                    pop;

  assign push = vld_user2fifo & ack_fifo2user;
  assign pop  = vld_fifo2interface & ack_interface2fifo;

  always_comb begin
    occ_next = occupancy;
    if (push && !pop)
      occ_next = occupancy + 1'b1;
    else if (pop && !push)
      occ_next = occupancy - 1'b1;
  end

  // Flags are registered from next-cycle occupancy, so ack_fifo2user never
  // depends combinationally on ack_interface2fifo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occupancy          <= '0;
      xfer_cnt           <= '0;
      ack_fifo2user      <= 1'b0;
      vld_fifo2interface <= 1'b0;
      almost_full        <= 1'b0;
    end else if (clear) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      occupancy          <= '0;
      xfer_cnt           <= '0;
      ack_fifo2user      <= 1'b1;
      vld_fifo2interface <= 1'b0;
      almost_full        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        xfer_cnt <= xfer_cnt + 32'd1;
      end
      occupancy          <= occ_next;
      ack_fifo2user      <= (occ_next < DEPTH_LVL);
      vld_fifo2interface <= (occ_next != '0);
      almost_full        <= (occ_next >= AF_LVL);
    end
  end

  // NOTE: the storage array has no reset; its contents are only visible
  // behind vld_fifo2interface, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= din_user2fifo;
  end

  // Gating with valid gives a defined zero on dout while empty or in reset.
  assign dout_fifo2interface = vld_fifo2interface ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_user_stream_fifo.sv
// Self-checking bench for user_stream_fifo: directed scenarios plus a random
// stream, all compared against a queue-based model of the buffer.
module tb_user_stream_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] din;
  logic        vld_u;
  logic        ack_u;
  logic [31:0] dout;
  logic        vld_i;
  logic        ack_i;
  logic [4:0]  occupancy;
  logic        almost_full;
  logic [31:0] xfer_cnt;

  user_stream_fifo dut (
    .clk                 (clk),
    .reset               (reset),
    .clear               (clear),
    .din_user2fifo       (din),
    .vld_user2fifo       (vld_u),
    .ack_fifo2user       (ack_u),
    .dout_fifo2interface (dout),
    .vld_fifo2interface  (vld_i),
    .ack_interface2fifo  (ack_i),
    .occupancy           (occupancy),
    .almost_full         (almost_full),
    .xfer_cnt            (xfer_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q[$];
  logic        m_ack;
  logic [31:0] m_xfer;
  int          m_pops;
  logic        last_push;
  logic        beef_seen = 1'b0;

  always @(posedge clk)
    if (!reset && vld_i && ack_i && dout == 32'hDEAD_BEEF) beef_seen <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_occ"}, 32'(occupancy), q.size());
    chk({tag, "_vld"}, 32'(vld_i), 32'(q.size() != 0));
    chk({tag, "_ack"}, 32'(ack_u), 32'(m_ack));
    chk({tag, "_af"}, 32'(almost_full), 32'(q.size() >= AF));
    chk({tag, "_xfer"}, xfer_cnt, m_xfer);
    if (q.size() != 0) chk({tag, "_dout"}, dout, q[0]);
  endtask

  // Advance one edge, update the model from the rules, then check at negedge.
  task automatic cycle(input string tag);
    logic push, pop;
    @(posedge clk);
    push = 1'b0;
    if (!reset) begin
      push = vld_u && m_ack;
      pop  = (q.size() != 0) && ack_i;
      if (clear) begin
        q.delete();
        m_xfer = 0;
        push   = 1'b0;
      end else begin
        if (pop) begin
          void'(q.pop_front());
          m_xfer++;
          m_pops++;
        end
        if (push) q.push_back(din);
      end
      m_ack = (q.size() < DEPTH);
    end
    last_push = push;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_clear();
    vld_u = 1'b0;
    ack_i = 1'b0;
    clear = 1'b1;
    cycle("clr");
    clear = 1'b0;
  endtask

  task automatic drain(input string tag);
    vld_u = 1'b0;
    ack_i = 1'b1;
    for (int n = 0; n < 40 && q.size() != 0; n++) cycle(tag);
    chk({tag, "_empty"}, 32'(occupancy), 0);
    ack_i = 1'b0;
  endtask

  initial begin
    int i, npush, ncyc, max_occ;
    reset = 1'b1; clear = 1'b0; vld_u = 1'b1; din = 32'hA5A5_0001; ack_i = 1'b0;
    m_ack = 1'b0; m_xfer = 0; m_pops = 0; last_push = 1'b0;

    // Reset release with a word already offered
    #12;
    chk("rst_ack", 32'(ack_u), 0);
    chk("rst_vld", 32'(vld_i), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_dout", dout, 0);
    @(negedge clk);
    reset = 1'b0;
    cycle("rel1");
    chk("rel1_ack_up", 32'(ack_u), 1);
    chk("rel1_vld_low", 32'(vld_i), 0);
    cycle("rel2");
    vld_u = 1'b0;
    chk("rel2_vld", 32'(vld_i), 1);
    chk("rel2_dout", dout, 32'hA5A5_0001);
    drain("rel_drain");

    // Fill to full, then offer one more word that must be dropped
    do_clear();
    for (int k = 0; k < DEPTH; k++) begin
      vld_u = 1'b1;
      din   = k;
      cycle("fill");
      if (k == 10) chk("fill_af_11", 32'(almost_full), 0);
      if (k == 11) chk("fill_af_12", 32'(almost_full), 1);
    end
    din = 32'h10;
    repeat (3) cycle("full");
    chk("full_occ", 32'(occupancy), 16);
    chk("full_ack", 32'(ack_u), 0);
    chk("full_af", 32'(almost_full), 1);
    drain("fill_drain");
    chk("fill_xfer", xfer_cnt, 16);

    // Continuous streaming, both sides always ready
    do_clear();
    ack_i = 1'b1; vld_u = 1'b1; din = 0; i = 0;
    for (int n = 0; n < 400 && m_xfer < 100; n++) begin
      cycle("stream");
      if (last_push) begin
        chk("stream_occ1", 32'(occupancy), 1);
        i++;
        if (i == 100) vld_u = 1'b0;
        else din = i;
      end
    end
    chk("stream_xfer", xfer_cnt, 100);

    // Random valid/ready at 50% each for 10000 words
    do_clear();
    m_pops = 0; npush = 0; ncyc = 0; max_occ = 0;
    while (m_pops < 10000 && ncyc < 60000) begin
      if (last_push) npush++;
      if (!vld_u || last_push) begin
        if (npush < 10000) begin
          vld_u = 1'($urandom_range(0, 1));
          din   = $urandom;
        end else vld_u = 1'b0;
      end
      ack_i = 1'($urandom_range(0, 1));
      cycle("rand");
      ncyc++;
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    end
    chk("rand_words", m_pops, 10000);
    chk("rand_max_occ_ok", 32'(max_occ <= DEPTH), 1);
    chk("rand_xfer", xfer_cnt, 10000);

    // clear at occupancy 7 with a simultaneous push
    do_clear();
    for (int k = 0; k < 9; k++) begin
      vld_u = 1'b1;
      din   = 32'h100 + k;
      cycle("pre_clr");
    end
    vld_u = 1'b0; ack_i = 1'b1;
    repeat (2) cycle("pre_clr_pop");
    ack_i = 1'b0;
    chk("pre_clr_occ7", 32'(occupancy), 7);
    vld_u = 1'b1; din = 32'hDEAD_BEEF; clear = 1'b1;
    cycle("clr7");
    clear = 1'b0; vld_u = 1'b0;
    chk("clr7_occ", 32'(occupancy), 0);
    chk("clr7_vld", 32'(vld_i), 0);
    chk("clr7_xfer", xfer_cnt, 0);
    chk("clr7_ack", 32'(ack_u), 1);
    for (int k = 0; k < 3; k++) begin
      vld_u = 1'b1;
      din   = 32'h200 + k;
      cycle("post_clr");
    end
    drain("post_clr_drain");

    // Asynchronous reset between edges at occupancy 5
    do_clear();
    for (int k = 0; k < 8; k++) begin
      vld_u = 1'b1;
      din   = 32'h300 + k;
      cycle("pre_rst");
    end
    vld_u = 1'b0; ack_i = 1'b1;
    repeat (3) cycle("pre_rst_pop");
    ack_i = 1'b0;
    chk("pre_rst_occ5", 32'(occupancy), 5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_occ", 32'(occupancy), 0);
    chk("mid_rst_vld", 32'(vld_i), 0);
    chk("mid_rst_ack", 32'(ack_u), 0);
    chk("mid_rst_af", 32'(almost_full), 0);
    chk("mid_rst_xfer", xfer_cnt, 0);
    chk("mid_rst_dout", dout, 0);
    q.delete(); m_ack = 1'b0; m_xfer = 0;
    cycle("in_rst");
    reset = 1'b0;
    vld_u = 1'b1; ack_i = 1'b1; din = 32'h400; i = 0;
    for (int n = 0; n < 20 && i < 4; n++) begin
      cycle("restart");
      if (last_push) begin
        i++;
        din = 32'h400 + i;
      end
    end
    drain("restart_drain");
    chk("restart_xfer", xfer_cnt, 4);

    chk("beef_never_out", 32'(beef_seen), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
